// File: rtl/adc_sequencer_if.sv
// adc_sequencer_if: start/config/comparator inputs and SAR timing strobes, result and status outputs
interface adc_sequencer_if #(
  parameter int NBITS = 16,
  parameter int SAMPW = 8
);
  logic             start;
  logic             cont;
  logic             stop;
  logic [SAMPW-1:0] cfg_samp_cycles;
  logic [4:0]       cfg_ncomp;
  logic             comp_out;
  logic             seq_init;
  logic             seq_samp;
  logic             seq_comp;
  logic             seq_update;
  logic             busy;
  logic             done;
  logic [NBITS-1:0] result;
  logic             start_err;
  modport master (
    output start, cont, stop, cfg_samp_cycles, cfg_ncomp, comp_out,
    input  seq_init, seq_samp, seq_comp, seq_update, busy, done, result, start_err
  );
  modport slave (
    input  start, cont, stop, cfg_samp_cycles, cfg_ncomp, comp_out,
    output seq_init, seq_samp, seq_comp, seq_update, busy, done, result, start_err
  );
endinterface

// File: rtl/adc_sequencer.sv
// adc_sequencer: SAR conversion controller issuing init/sample/compare/update strobes, MSB-first result
module adc_sequencer #(
  parameter int NBITS = 16,
  parameter int SAMPW = 8
) (
  input logic          clk,
  input logic          rst,
  adc_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, INIT, SAMP, COMP, CAPT, UPD, DONE} state_t;
  state_t           r_state, w_next;
  logic [SAMPW-1:0] r_s, r_cnt;
  logic [4:0]       r_n, r_k, w_k1;
  logic             r_cont, w_go;
  logic [NBITS-1:0] r_shift;
  assign w_go = r_state == IDLE && bus.start;
  assign w_k1 = r_k + 5'd1;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = bus.start ? INIT : IDLE;
      INIT:    w_next = SAMP;
      SAMP:    w_next = r_cnt == '0 ? COMP : SAMP;
      COMP:    w_next = CAPT;
      CAPT:    w_next = UPD;
      UPD:     w_next = w_k1 < r_n ? COMP : DONE;
      DONE:    w_next = r_cont && !bus.stop ? INIT : IDLE;
      default: w_next = IDLE;
    endcase
  end
  // outputs are registered from the next state so they align with the state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_s            <= '0;
      r_n            <= '0;
      r_cnt          <= '0;
      r_k            <= '0;
      r_cont         <= 1'b0;
      r_shift        <= '0;
      bus.seq_init   <= 1'b0;
      bus.seq_samp   <= 1'b0;
      bus.seq_comp   <= 1'b0;
      bus.seq_update <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.result     <= '0;
      bus.start_err  <= 1'b0;
    end else begin
      r_state        <= w_next;
      bus.seq_init   <= w_next == INIT;
      bus.seq_samp   <= w_next == SAMP;
      bus.seq_comp   <= w_next == COMP;
      bus.seq_update <= w_next == UPD;
      bus.busy       <= w_next != IDLE;
      bus.done       <= w_next == DONE;
      if (w_go) begin
        r_s           <= bus.cfg_samp_cycles == '0 ? SAMPW'(1) : bus.cfg_samp_cycles;
        r_n           <= bus.cfg_ncomp == '0 ? 5'd1 :
                         bus.cfg_ncomp > 5'(NBITS) ? 5'(NBITS) : bus.cfg_ncomp;
        r_cont        <= bus.cont;
        bus.start_err <= 1'b0;
      end else if (r_state != IDLE) begin
        if (bus.start) bus.start_err <= 1'b1;
        if (bus.stop) r_cont <= 1'b0;
      end
      if (w_next == INIT) begin
        r_shift <= '0;
        r_k     <= '0;
      end
      if (r_state == INIT) r_cnt <= r_s - SAMPW'(1);
      else if (r_state == SAMP) r_cnt <= r_cnt - SAMPW'(1);
      for (int i = 0; i < NBITS; i++)
        if (r_state == CAPT && i == NBITS - 1 - int'(r_k)) r_shift[i] <= bus.comp_out;
      if (r_state == UPD) r_k <= w_k1;
      if (w_next == DONE) bus.result <= r_shift;
    end
  end
endmodule

// File: tb/tb_adc_sequencer.sv
// tb_adc_sequencer: randomized jobs against a cycle-arithmetic model; done/result scoreboarded via a queue
module tb_adc_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  adc_sequencer_if #(.NBITS(16), .SAMPW(8)) bus();
  adc_sequencer #(.NBITS(16), .SAMPW(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    int          due;
    logic [15:0] res;
  } exp_t;
  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  bit   active = 1'b0;
  bit   mon_en = 1'b0;
  int   t_start, j_s, j_n, j_m, j_p, bs_rel;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %h, want %h (cycle %0d)", name, got, want, cyc);
  endtask
  // model: each conversion is a period of S+2+3N cycles after the accepting edge
  initial begin : monitor
    logic [6:0] e;
    int rel, r, q;
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        e = '0;
        if (active) begin
          rel = cyc - t_start + 1;
          if (rel <= j_m * j_p) begin
            r = (rel - 1) % j_p + 1;
            q = r - j_s - 2;
            e[6] = 1'b1;
            e[5] = r == 1;
            e[4] = r >= 2 && r <= j_s + 1;
            e[3] = q >= 0 && q < 3 * j_n && q % 3 == 0;
            e[2] = q >= 0 && q < 3 * j_n && q % 3 == 2;
            e[1] = r == j_p;
          end
          e[0] = bs_rel != 0 && rel > bs_rel;
        end
        check("strobes{busy,init,samp,comp,upd,done,err}",
              {25'd0, bus.busy, bus.seq_init, bus.seq_samp, bus.seq_comp, bus.seq_update, bus.done, bus.start_err},
              {25'd0, e});
        if (bus.done === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL done_unexpected: got done at cycle %0d, want no done", cyc);
          end else begin
            x = exp_q.pop_front();
            check("done_cycle", cyc, x.due);
            check("result", {16'd0, bus.result}, {16'd0, x.res});
          end
        end
      end
    end
  end
  task automatic drive_noise();
    bus.cont            = 1'($urandom);
    bus.cfg_samp_cycles = 8'($urandom);
    bus.cfg_ncomp       = 5'($urandom);
    bus.comp_out        = 1'($urandom);
  endtask
  task automatic idle_gap(input int g);
    repeat (g) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.stop  = 1'($urandom);
      drive_noise();
    end
  endtask
  task automatic run_job(input int cs, input int cn, input bit ct, input int m, input int bs,
                         input int rst_at, input logic [15:0] w0);
    int s, n, p, stop_at, r, c, q;
    logic [15:0] words[$];
    logic [15:0] msk;
    s = cs == 0 ? 1 : cs;
    n = cn == 0 ? 1 : (cn > 16 ? 16 : cn);
    p = s + 2 + 3 * n;
    words = {w0};
    for (int i = 1; i < m; i++) words.push_back(16'($urandom));
    if (bs < 0) bs = $urandom_range(0, 1) == 1 ? int'($urandom_range(1, m * p)) : 0;
    stop_at = ct ? (m - 1) * p + int'($urandom_range(1, p)) : 0;
    msk = ~(16'hFFFF >> n);
    @(negedge clk);
    drive_noise();
    bus.start           = 1'b1;
    bus.stop            = 1'($urandom);
    bus.cont            = ct;
    bus.cfg_samp_cycles = 8'(cs);
    bus.cfg_ncomp       = 5'(cn);
    t_start = cyc + 1;
    j_s = s;
    j_n = n;
    j_m = m;
    j_p = p;
    bs_rel = bs;
    active = 1'b1;
    for (int i = 0; i < m; i++) exp_q.push_back('{t_start + i * p + p - 1, words[i] & msk});
    for (int rel = 1; rel <= m * p; rel++) begin
      @(negedge clk);
      if (rel == rst_at) begin
        rst = 1'b1;
        active = 1'b0;
        bs_rel = 0;
        exp_q.delete();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("reset_result", {16'd0, bus.result}, 32'd0);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        return;
      end
      r = (rel - 1) % p + 1;
      c = (rel - 1) / p;
      q = r - s - 3;
      drive_noise();
      bus.start = rel == bs;
      bus.stop  = rel == stop_at || (!ct && $urandom_range(0, 7) == 0);
      if (q >= 0 && q % 3 == 0 && q / 3 < n) bus.comp_out = words[c][15 - q / 3];
    end
  endtask
  initial begin : driver
    int cs, cn, m;
    bit ct;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    drive_noise();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    idle_gap(2);
    run_job(4, 16, 1'b0, 1, 10, 0, 16'hAC35);
    idle_gap(1);
    run_job(0, 0, 1'b0, 1, 0, 0, 16'hFFFF);
    run_job(0, 20, 1'b0, 1, 0, 0, 16'hFFFF);
    idle_gap(2);
    run_job(2, 4, 1'b1, 3, 48, 0, 16'($urandom));
    run_job(3, 8, 1'b0, 1, 0, 0, 16'($urandom));
    run_job(3, 3, 1'b0, 1, 0, 0, 16'($urandom));
    run_job(4, 16, 1'b0, 1, 0, 20, 16'($urandom));
    idle_gap(2);
    run_job(4, 16, 1'b0, 1, 0, 0, 16'($urandom));
    repeat (30) begin
      idle_gap($urandom_range(0, 2));
      cs = $urandom_range(0, 6);
      cn = $urandom_range(0, 20);
      ct = 1'($urandom);
      m  = ct ? int'($urandom_range(1, 3)) : 1;
      run_job(cs, cn, ct, m, -1, 0, 16'($urandom));
    end
    idle_gap(4);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
